axi_sram_slave: RTL and testbench

AXI3 slave responder backed by a byte-writable on-chip memory. It is the far end of the CPU's AXI master port (I/D cache refills and write-backs through the bridge) and replaces the external RAM model in standalone simulation and FPGA bring-up. Independent read and write engines each hold one outstanding transaction and support INCR/FIXED bursts of 1–16 beats.

---
 rtl/axi_slv_pkg.sv | 26 ++
 rtl/axi_slv_ram.sv | 30 +++
 rtl/axi_sram_slave.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slv_pkg.sv
// rtl/axi_slv_pkg.sv - shared constants, FSM state types and burst address helper
package axi_slv_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [2:0] SIZE_MAX = 3'b010;

   typedef enum logic [0:0] {R_IDLE, R_BURST} rd_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

   // FIXED holds the address; INCR, WRAP (treated as INCR) and reserved codes step by the beat size
   function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                             input logic [2:0]  size,
                                             input logic [1:0]  burst);
      if (burst == BURST_FIXED) begin
         return addr;
      end
      return addr + (32'd1 << size);
   endfunction

endpackage

// File: rtl/axi_slv_ram.sv
// rtl/axi_slv_ram.sv - word array with asynchronous read port and byte-lane write port
module axi_slv_ram #(
   parameter int    ADDR_W    = 14,
   parameter string INIT_FILE = ""
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] rd_idx,
   output logic [31:0]       rd_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_idx,
   input  logic [3:0]        wr_strb,
   input  logic [31:0]       wr_data
);

   logic [31:0] mem [0:(1<<ADDR_W)-1];

   // byte-lane write; a read of the same word this cycle still sees the old value
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) begin
               mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI3 slave with independent single-outstanding read and write engines
module axi_sram_slave
   import axi_slv_pkg::*;
#(
   parameter int          ADDR_W    = 14,
   parameter logic [31:0] ADDR_BASE = 32'h1c00_0000,
   parameter string       INIT_FILE = ""
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic [3:0]  arid,
   input  logic [31:0] araddr,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   input  logic [1:0]  arlock,
   input  logic [3:0]  arcache,
   input  logic [2:0]  arprot,
   input  logic        arvalid,
   output logic        arready,
   output logic [3:0]  rid,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready,
   input  logic [3:0]  awid,
   input  logic [31:0] awaddr,
   input  logic [7:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   input  logic [1:0]  awlock,
   input  logic [3:0]  awcache,
   input  logic [2:0]  awprot,
   input  logic        awvalid,
   output logic        awready,
   input  logic [3:0]  wid,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,
   output logic [3:0]  bid,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   function automatic logic in_range(input logic [31:0] a);
      return a[31:ADDR_W+2] == ADDR_BASE[31:ADDR_W+2];
   endfunction

   logic unused_sideband;
   assign unused_sideband = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

   // ---------------- read engine state ----------------
   rd_state_t   rstate_q, rstate_d;
   logic [31:0] raddr_q, raddr_d;
   logic [7:0]  rlen_q, rlen_d;
   logic [7:0]  rcnt_q, rcnt_d;
   logic [2:0]  rsize_q, rsize_d;
   logic [1:0]  rburst_q, rburst_d;
   logic [3:0]  rid_q, rid_d;
   logic        arready_q, arready_d;
   logic        rvalid_q, rvalid_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  rresp_q, rresp_d;
   logic        rlast_q, rlast_d;

   // ---------------- write engine state ----------------
   wr_state_t   wstate_q, wstate_d;
   logic [31:0] waddr_q, waddr_d;
   logic [7:0]  wlen_q, wlen_d;
   logic [7:0]  wcnt_q, wcnt_d;
   logic [2:0]  wsize_q, wsize_d;
   logic [1:0]  wburst_q, wburst_d;
   logic [3:0]  bid_q, bid_d;
   logic        err_q, err_d;
   logic        awready_q, awready_d;
   logic        wready_q, wready_d;
   logic        bvalid_q, bvalid_d;
   logic [1:0]  bresp_q, bresp_d;

   // the read port looks at the beat about to be presented: the new AR address or the next burst address
   logic        ar_hs, r_hs;
   logic [31:0] raddr_nx, rbeat_addr;
   logic [2:0]  rbeat_size;
   logic        rbeat_ok;
   logic [31:0] ram_rd_data;

   assign ar_hs      = arvalid & arready_q;
   assign r_hs       = rvalid_q & rready;
   assign raddr_nx   = next_addr(raddr_q, rsize_q, rburst_q);
   assign rbeat_addr = ar_hs ? araddr : raddr_nx;
   assign rbeat_size = ar_hs ? arsize : rsize_q;
   assign rbeat_ok   = in_range(rbeat_addr) && (rbeat_size <= SIZE_MAX);

   logic aw_hs, w_hs, b_hs, wbeat_ok, ram_we;

   assign aw_hs    = awvalid & awready_q;
   assign w_hs     = wvalid & wready_q;
   assign b_hs     = bvalid_q & bready;
   assign wbeat_ok = in_range(waddr_q) && (wsize_q <= SIZE_MAX);
   assign ram_we   = (wstate_q == W_DATA) && w_hs && wbeat_ok;

   axi_slv_ram #(
      .ADDR_W    (ADDR_W),
      .INIT_FILE (INIT_FILE)
   ) u_ram (
      .clk     (aclk),
      .rd_idx  (rbeat_addr[ADDR_W+1:2]),
      .rd_data (ram_rd_data),
      .wr_en   (ram_we),
      .wr_idx  (waddr_q[ADDR_W+1:2]),
      .wr_strb (wstrb),
      .wr_data (wdata)
   );

   // read engine next state: beat data is captured when the beat is loaded and held until accepted
   always_comb begin
      rstate_d = rstate_q;
      raddr_d  = raddr_q;
      rlen_d   = rlen_q;
      rcnt_d   = rcnt_q;
      rsize_d  = rsize_q;
      rburst_d = rburst_q;
      rid_d    = rid_q;
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      rlast_d  = rlast_q;
      case (rstate_q)
         R_IDLE: begin
            if (ar_hs) begin
               rstate_d = R_BURST;
               raddr_d  = araddr;
               rlen_d   = arlen;
               rcnt_d   = 8'd0;
               rsize_d  = arsize;
               rburst_d = arburst;
               rid_d    = arid;
               rvalid_d = 1'b1;
               rdata_d  = rbeat_ok ? ram_rd_data : 32'd0;
               rresp_d  = rbeat_ok ? RESP_OKAY : RESP_SLVERR;
               rlast_d  = (arlen == 8'd0);
            end
         end
         R_BURST: begin
            if (r_hs) begin
               if (rlast_q) begin
                  rstate_d = R_IDLE;
                  rvalid_d = 1'b0;
                  rdata_d  = 32'd0;
                  rresp_d  = RESP_OKAY;
                  rlast_d  = 1'b0;
               end else begin
                  raddr_d = raddr_nx;
                  rcnt_d  = rcnt_q + 8'd1;
                  rdata_d = rbeat_ok ? ram_rd_data : 32'd0;
                  rresp_d = rbeat_ok ? RESP_OKAY : RESP_SLVERR;
                  rlast_d = ((rcnt_q + 8'd1) == rlen_q);
               end
            end
         end
         default: rstate_d = R_IDLE;
      endcase
      arready_d = (rstate_d == R_IDLE);
   end

   // write engine next state: error is sticky across the burst and reported in the single response
   always_comb begin
      logic last_by_cnt;
      logic err_nx;
      wstate_d    = wstate_q;
      waddr_d     = waddr_q;
      wlen_d      = wlen_q;
      wcnt_d      = wcnt_q;
      wsize_d     = wsize_q;
      wburst_d    = wburst_q;
      bid_d       = bid_q;
      err_d       = err_q;
      bresp_d     = bresp_q;
      last_by_cnt = (wcnt_q == wlen_q);
      err_nx      = err_q | ~wbeat_ok | (wlast != last_by_cnt);
      case (wstate_q)
         W_IDLE: begin
            if (aw_hs) begin
               wstate_d = W_DATA;
               waddr_d  = awaddr;
               wlen_d   = awlen;
               wcnt_d   = 8'd0;
               wsize_d  = awsize;
               wburst_d = awburst;
               bid_d    = awid;
               err_d    = 1'b0;
            end
         end
         W_DATA: begin
            if (w_hs) begin
               err_d = err_nx;
               if (wlast || last_by_cnt) begin
                  wstate_d = W_RESP;
                  bresp_d  = err_nx ? RESP_SLVERR : RESP_OKAY;
               end else begin
                  waddr_d = next_addr(waddr_q, wsize_q, wburst_q);
                  wcnt_d  = wcnt_q + 8'd1;
               end
            end
         end
         W_RESP: begin
            if (b_hs) begin
               wstate_d = W_IDLE;
               bresp_d  = RESP_OKAY;
            end
         end
         default: wstate_d = W_IDLE;
      endcase
      awready_d = (wstate_d == W_IDLE);
      wready_d  = (wstate_d == W_DATA);
      bvalid_d  = (wstate_d == W_RESP);
   end

   // read engine registers; reset abandons any burst without a response
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         rstate_q  <= R_IDLE;
         raddr_q   <= 32'd0;
         rlen_q    <= 8'd0;
         rcnt_q    <= 8'd0;
         rsize_q   <= 3'd0;
         rburst_q  <= 2'd0;
         rid_q     <= 4'd0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= 32'd0;
         rresp_q   <= 2'd0;
         rlast_q   <= 1'b0;
      end else begin
         rstate_q  <= rstate_d;
         raddr_q   <= raddr_d;
         rlen_q    <= rlen_d;
         rcnt_q    <= rcnt_d;
         rsize_q   <= rsize_d;
         rburst_q  <= rburst_d;
         rid_q     <= rid_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         rlast_q   <= rlast_d;
      end
   end

   // write engine registers
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         wstate_q  <= W_IDLE;
         waddr_q   <= 32'd0;
         wlen_q    <= 8'd0;
         wcnt_q    <= 8'd0;
         wsize_q   <= 3'd0;
         wburst_q  <= 2'd0;
         bid_q     <= 4'd0;
         err_q     <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'd0;
      end else begin
         wstate_q  <= wstate_d;
         waddr_q   <= waddr_d;
         wlen_q    <= wlen_d;
         wcnt_q    <= wcnt_d;
         wsize_q   <= wsize_d;
         wburst_q  <= wburst_d;
         bid_q     <= bid_d;
         err_q     <= err_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
      end
   end

   assign arready = arready_q;
   assign rid     = rid_q;
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;
   assign rlast   = rlast_q;
   assign rvalid  = rvalid_q;
   assign awready = awready_q;
   assign wready  = wready_q;
   assign bid     = bid_q;
   assign bresp   = bresp_q;
   assign bvalid  = bvalid_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - directed scoreboard bench for axi_sram_slave
module tb_axi_sram_slave;
   import axi_slv_pkg::*;

   logic        aclk, areset;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst, arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid, arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast, rvalid, rready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst, awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid, awready;
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast, wvalid, wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid, bready;

   axi_sram_slave dut (
      .aclk(aclk), .areset(areset),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   typedef struct {
      logic [3:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } rbeat_t;

   rbeat_t exp_q[$];
   int checks   = 0;
   int failures = 0;
   int rcount   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_beat(input logic [3:0] id, input logic [31:0] data,
                            input logic [1:0] resp, input logic last);
      rbeat_t b;
      b.id = id; b.data = data; b.resp = resp; b.last = last;
      exp_q.push_back(b);
   endtask

   // R channel monitor: scoreboard pop on handshake, stability check while stalled
   logic        held_v = 1'b0;
   logic [31:0] held_d;
   logic [1:0]  held_r;
   logic        held_l;
   logic [3:0]  held_id;
   initial begin
      forever begin
         @(negedge aclk);
         if (areset) begin
            held_v = 1'b0;
         end else if (rvalid) begin
            if (held_v) begin
               chk("r_hold_data", rdata, held_d);
               chk("r_hold_resp", {30'd0, rresp}, {30'd0, held_r});
               chk("r_hold_last", {31'd0, rlast}, {31'd0, held_l});
               chk("r_hold_id", {28'd0, rid}, {28'd0, held_id});
            end
            if (rready) begin
               checks++;
               assert (exp_q.size() != 0) else begin
                  failures++;
                  $error("FAIL r_unexpected_beat observed=%h expected=empty_scoreboard_entry", rdata);
               end
               if (exp_q.size() != 0) begin
                  rbeat_t e;
                  e = exp_q.pop_front();
                  chk("r_data", rdata, e.data);
                  chk("r_resp", {30'd0, rresp}, {30'd0, e.resp});
                  chk("r_last", {31'd0, rlast}, {31'd0, e.last});
                  chk("r_id", {28'd0, rid}, {28'd0, e.id});
               end
               held_v = 1'b0;
               rcount++;
            end else begin
               held_v  = 1'b1;
               held_d  = rdata;
               held_r  = rresp;
               held_l  = rlast;
               held_id = rid;
            end
         end
      end
   end

   // all driver tasks start and end at posedge+1
   task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int n;
      arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
      n = 0;
      @(negedge aclk);
      while (!arready && n < 50) begin
         @(negedge aclk);
         n++;
      end
      chk("ar_ready_timeout", {31'd0, arready}, 32'd1);
      @(posedge aclk);
      #1 arvalid = 1'b0;
   endtask

   task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int n;
      awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
      n = 0;
      @(negedge aclk);
      while (!awready && n < 50) begin
         @(negedge aclk);
         n++;
      end
      chk("aw_ready_timeout", {31'd0, awready}, 32'd1);
      @(posedge aclk);
      #1 awvalid = 1'b0;
   endtask

   task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
      int n;
      wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
      n = 0;
      @(negedge aclk);
      while (!wready && n < 50) begin
         @(negedge aclk);
         n++;
      end
      chk("w_ready_timeout", {31'd0, wready}, 32'd1);
      @(posedge aclk);
      #1 wvalid = 1'b0;
      wlast = 1'b0;
   endtask

   task automatic b_wait(input string tag, input logic [3:0] id, input logic [1:0] resp);
      int n;
      bready = 1'b1;
      n = 0;
      @(negedge aclk);
      while (!bvalid && n < 50) begin
         @(negedge aclk);
         n++;
      end
      chk({tag, "_bvalid"}, {31'd0, bvalid}, 32'd1);
      chk({tag, "_bid"}, {28'd0, bid}, {28'd0, id});
      chk({tag, "_bresp"}, {30'd0, bresp}, {30'd0, resp});
      @(posedge aclk);
      #1 bready = 1'b0;
   endtask

   task automatic rd_wait(input int target, input logic [7:0] pat, input int plen);
      int n;
      n = 0;
      while (rcount < target && n < 200) begin
         rready = pat[n % plen];
         @(posedge aclk);
         #1;
         n++;
      end
      rready = 1'b0;
      chk("r_beat_count", rcount, target);
   endtask

   task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
      aw_send(4'd0, addr, 8'd0, 3'd2, BURST_INCR);
      w_beat(data, 4'hF, 1'b1);
      b_wait("preload", 4'd0, RESP_OKAY);
   endtask

   task automatic read_one(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] exp);
      int base;
      base = rcount;
      push_beat(id, exp, RESP_OKAY, 1'b1);
      ar_send(id, addr, 8'd0, 3'd2, BURST_INCR);
      rd_wait(base + 1, 8'hFF, 1);
   endtask

   initial begin
      int base;
      areset = 1'b1;
      arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arlock = 0; arcache = 0; arprot = 0;
      arvalid = 0; rready = 0;
      awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awlock = 0; awcache = 0; awprot = 0;
      awvalid = 0; wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;

      // reset state
      repeat (3) @(negedge aclk);
      chk("rst_arready", {31'd0, arready}, 32'd0);
      chk("rst_awready", {31'd0, awready}, 32'd0);
      chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
      chk("rst_wready", {31'd0, wready}, 32'd0);
      chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
      @(posedge aclk);
      #1 areset = 1'b0;
      chk("rel_arready_before_edge", {31'd0, arready}, 32'd0);
      @(posedge aclk);
      #1;
      chk("rel_arready", {31'd0, arready}, 32'd1);
      chk("rel_awready", {31'd0, awready}, 32'd1);

      // 4-beat INCR read with back-pressure
      write_word(32'h1c00_0010, 32'h11);
      write_word(32'h1c00_0014, 32'h22);
      write_word(32'h1c00_0018, 32'h33);
      write_word(32'h1c00_001c, 32'h44);
      base = rcount;
      push_beat(4'd3, 32'h11, RESP_OKAY, 1'b0);
      push_beat(4'd3, 32'h22, RESP_OKAY, 1'b0);
      push_beat(4'd3, 32'h33, RESP_OKAY, 1'b0);
      push_beat(4'd3, 32'h44, RESP_OKAY, 1'b1);
      ar_send(4'd3, 32'h1c00_0010, 8'd3, 3'd2, BURST_INCR);
      rd_wait(base + 4, 8'b0010_1101, 6);

      // two-beat write with partial strobe
      write_word(32'h1c00_0100, 32'h0);
      write_word(32'h1c00_0104, 32'h0);
      aw_send(4'd5, 32'h1c00_0100, 8'd1, 3'd2, BURST_INCR);
      w_beat(32'hAABB_CCDD, 4'b0101, 1'b0);
      w_beat(32'h1234_5678, 4'hF, 1'b1);
      b_wait("wr_burst", 4'd5, RESP_OKAY);
      base = rcount;
      push_beat(4'd1, 32'h00BB_00DD, RESP_OKAY, 1'b0);
      push_beat(4'd1, 32'h1234_5678, RESP_OKAY, 1'b1);
      ar_send(4'd1, 32'h1c00_0100, 8'd1, 3'd2, BURST_INCR);
      rd_wait(base + 2, 8'hFF, 1);

      // out-of-range read and write
      write_word(32'h1c00_0000, 32'hCAFE_F00D);
      base = rcount;
      push_beat(4'd2, 32'h0, RESP_SLVERR, 1'b1);
      ar_send(4'd2, 32'h0000_0000, 8'd0, 3'd2, BURST_INCR);
      rd_wait(base + 1, 8'hFF, 1);
      aw_send(4'd2, 32'h0000_0000, 8'd0, 3'd2, BURST_INCR);
      w_beat(32'hFFFF_FFFF, 4'hF, 1'b1);
      b_wait("wr_oor", 4'd2, RESP_SLVERR);
      read_one(4'd2, 32'h1c00_0000, 32'hCAFE_F00D);

      // same-cycle read and write of one word
      write_word(32'h1c00_0200, 32'h1);
      aw_send(4'd6, 32'h1c00_0200, 8'd0, 3'd2, BURST_INCR);
      base = rcount;
      push_beat(4'd9, 32'h1, RESP_OKAY, 1'b1);
      arid = 4'd9; araddr = 32'h1c00_0200; arlen = 8'd0; arsize = 3'd2; arburst = BURST_INCR;
      arvalid = 1'b1;
      wdata = 32'h2; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
      @(negedge aclk);
      chk("same_cyc_arready", {31'd0, arready}, 32'd1);
      chk("same_cyc_wready", {31'd0, wready}, 32'd1);
      @(posedge aclk);
      #1 arvalid = 1'b0;
      wvalid = 1'b0;
      wlast = 1'b0;
      rd_wait(base + 1, 8'hFF, 1);
      b_wait("same_cyc", 4'd6, RESP_OKAY);
      read_one(4'd9, 32'h1c00_0200, 32'h2);

      // FIXED burst and early wlast
      aw_send(4'd7, 32'h1c00_0300, 8'd3, 3'd2, BURST_FIXED);
      w_beat(32'h1, 4'hF, 1'b0);
      w_beat(32'h2, 4'hF, 1'b0);
      w_beat(32'h3, 4'hF, 1'b0);
      w_beat(32'h4, 4'hF, 1'b1);
      b_wait("wr_fixed", 4'd7, RESP_OKAY);
      read_one(4'd7, 32'h1c00_0300, 32'h4);
      aw_send(4'd4, 32'h1c00_0304, 8'd3, 3'd2, BURST_INCR);
      w_beat(32'h5, 4'hF, 1'b0);
      w_beat(32'h6, 4'hF, 1'b1);
      b_wait("wr_early_last", 4'd4, RESP_SLVERR);

      // reset during beat 2 of a 4-beat read
      push_beat(4'd7, 32'h11, RESP_OKAY, 1'b0);
      push_beat(4'd7, 32'h22, RESP_OKAY, 1'b0);
      push_beat(4'd7, 32'h33, RESP_OKAY, 1'b0);
      push_beat(4'd7, 32'h44, RESP_OKAY, 1'b1);
      ar_send(4'd7, 32'h1c00_0010, 8'd3, 3'd2, BURST_INCR);
      rready = 1'b1;
      @(posedge aclk);
      #1 rready = 1'b0;
      chk("midrst_beat2_valid", {31'd0, rvalid}, 32'd1);
      areset = 1'b1;
      #1;
      chk("midrst_rvalid", {31'd0, rvalid}, 32'd0);
      chk("midrst_arready", {31'd0, arready}, 32'd0);
      exp_q.delete();
      @(posedge aclk);
      #1 areset = 1'b0;
      chk("midrst_arready_pre", {31'd0, arready}, 32'd0);
      @(posedge aclk);
      #1;
      chk("midrst_arready_post", {31'd0, arready}, 32'd1);
      base = rcount;
      push_beat(4'd8, 32'h11, RESP_OKAY, 1'b0);
      push_beat(4'd8, 32'h22, RESP_OKAY, 1'b0);
      push_beat(4'd8, 32'h33, RESP_OKAY, 1'b0);
      push_beat(4'd8, 32'h44, RESP_OKAY, 1'b1);
      ar_send(4'd8, 32'h1c00_0010, 8'd3, 3'd2, BURST_INCR);
      rd_wait(base + 4, 8'hFF, 1);

      repeat (2) @(posedge aclk);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
